if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline register of the five-stage CPU, directly downstream of the program counter.
- Latches the fetched instruction and its address for decode.
- Detects load-use hazards and drives PCdelay/prePC back to the program counter to freeze fetch.
- Squashes the fetched instruction when a taken branch/jump (PCSrc) redirects the PC.

Parameters:
- WIDTH, 32, address and instruction width.
- NOP_INSTR, 32'h0000_0000, encoding inserted on flush and after reset.

Ports:
- CLK  input  1  clock, all state on posedge.
- Reset  input  1  synchronous, active-high reset.
- curPC  input  WIDTH  address currently being fetched, from the program counter.
- IF_Instr  input  WIDTH  instruction memory read data for curPC (combinational, same cycle).
- PCSrc  input  1  taken branch/jump resolved this cycle; same signal the program counter consumes.
- EX_MemRead  input  1  instruction in ID/EX is a load.
- EX_Rt  input  5  destination register of the load in ID/EX.
- ID_PC  output  WIDTH  registered address of the instruction in decode.
- ID_Instr  output  WIDTH  registered instruction in decode.
- ID_Valid  output  1  ID_Instr is a real instruction (0 = bubble/NOP).
- PCdelay  output  1  hold request to the program counter, combinational.
- prePC  output  WIDTH  address the program counter reloads while PCdelay=1; equals curPC.
- Bubble  output  1  ID/EX must load zeroed control this cycle, combinational.

Behaviour:
- Reset (sync, highest priority): ID_PC=0, ID_Instr=NOP_INSTR, ID_Valid=0, state=RUN. PCdelay and Bubble are 0 while Reset=1.
- Hazard condition, combinational:
  - haz = (state==RUN) & ID_Valid & EX_MemRead & (EX_Rt!=0) & ((EX_Rt==ID_Instr[25:21]) | (EX_Rt==ID_Instr[20:16])).
- PCdelay = haz & ~PCSrc. Bubble = haz & ~PCSrc. prePC = curPC in all cycles.
- States: RUN, STALL.
  - RUN, PCSrc=1 (flush):
    - ID_Instr<=NOP_INSTR, ID_Valid<=0, ID_PC<=curPC; stay RUN.
    - A flush overrides a concurrent hazard: the hazard instruction is itself squashed.
  - RUN, haz & ~PCSrc (stall):
    - ID_PC, ID_Instr and ID_Valid are held.
    - Next state STALL.
  - RUN, otherwise:
    - ID_PC<=curPC, ID_Instr<=IF_Instr, ID_Valid<=1.
  - STALL: exactly one cycle.
    - haz is forced 0 so the stall is not re-triggered by the bubble now in EX.
    - If PCSrc=1, flush as in RUN; otherwise load normally.
    - Next state RUN.
- Latency: one cycle IF->ID. A load-use hazard costs exactly one bubble cycle. A flush costs one NOP in ID.
- Back-to-back load-use (the new ID instruction depends on a new load) may stall again in the cycle after STALL returns to RUN.
- Reset asserted in STALL returns to RUN with cleared outputs; no pending stall survives.
- No arithmetic on addresses; widths pass through unchanged.
- Register-field compare uses ID_Instr even when opcode has no rt source. This conservative extra stall is accepted.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- When defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0], both reset to 0.
  - StallCount increments each cycle PCdelay=1.
  - FlushCount increments each cycle a flush loads a NOP.
  - Both wrap from 32'hFFFF_FFFF to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run with curPC=0,4,8 and IF_Instr=A,B,C -> ID_PC/ID_Instr follow one cycle later (0/A, 4/B, 8/C), ID_Valid=1 from the first post-reset edge, PCdelay=0 throughout.
- ID_Instr=32'h0128_5020 (rs=9, rt=8) with EX_MemRead=1, EX_Rt=8 -> PCdelay=1, Bubble=1, prePC=curPC for one cycle; ID regs held; the next cycle is STALL with PCdelay=0; the following edge loads the next instruction.
- Same as above but EX_Rt=0 or EX_MemRead=0 -> no stall.
- PCSrc=1 while ID holds a valid instruction -> next cycle ID_Instr=NOP_INSTR, ID_Valid=0; PCSrc=1 together with a hazard -> PCdelay=0 and flush wins.
- Reset asserted during STALL -> next cycle ID_PC=0, ID_Valid=0, state RUN, PCdelay=0.
- With IF_ID_PERF_CNT_EN: two hazards and one flush -> StallCount=2, FlushCount=1; preload StallCount to 32'hFFFF_FFFF, trigger a hazard -> StallCount=0.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and branch flush.
// Define IF_ID_PERF_CNT_EN to add the StallCount/FlushCount performance counters.
module if_id_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] curPC,
  input  logic [WIDTH-1:0] IF_Instr,
  input  logic             PCSrc,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  output logic [WIDTH-1:0] ID_PC,
  output logic [WIDTH-1:0] ID_Instr,
  output logic             ID_Valid,
  output logic             PCdelay,
  output logic [WIDTH-1:0] prePC,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0]      StallCount,
  output logic [31:0]      FlushCount,
`endif
  output logic             Bubble
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic [WIDTH-1:0] id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;

  logic [4:0] id_rs, id_rt;
  logic       rt_match;
  logic       haz;
  logic       stall;
  logic       flush;

  assign id_rs    = id_instr_q[25:21];
  assign id_rt    = id_instr_q[20:16];
  assign rt_match = (EX_Rt == id_rs) || (EX_Rt == id_rt);

  // The STALL state masks detection: the load has moved on and EX now holds the bubble.
  assign haz = (state_q == StRun) && id_valid_q && EX_MemRead && (EX_Rt != 5'd0) && rt_match;

  assign stall = haz && !PCSrc && !Reset;
  assign flush = PCSrc && !Reset;

  assign PCdelay = stall;
  assign Bubble  = stall;
  assign prePC   = curPC;

  assign ID_PC    = id_pc_q;
  assign ID_Instr = id_instr_q;
  assign ID_Valid = id_valid_q;

  always_comb begin
    state_d    = StRun;
    id_pc_d    = curPC;
    id_instr_d = IF_Instr;
    id_valid_d = 1'b1;
    if (PCSrc) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (haz) begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      state_d    = StStall;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StRun;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters wrap naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

`ifndef SYNTHESIS
  // A stall is never requested in the same cycle as a redirect.
  assert property (@(posedge CLK) PCdelay |-> !PCSrc);
  // STALL always lasts exactly one cycle.
  assert property (@(posedge CLK) disable iff (Reset) (state_q == StStall) |=> (state_q == StRun));
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage; expected outputs are queued per cycle
// by the driver and compared by an independent monitor just before each posedge.
module tb_if_id_stage;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] NOP = 32'h0000_0000;
  localparam logic [W-1:0] IA  = 32'h2002_0001;
  localparam logic [W-1:0] IB  = 32'h2003_0002;
  localparam logic [W-1:0] IC  = 32'h2004_0003;
  localparam logic [W-1:0] ID  = 32'h2005_0004;
  localparam logic [W-1:0] IE  = 32'h2006_0005;
  localparam logic [W-1:0] IF  = 32'h2007_0006;
  localparam logic [W-1:0] IH  = 32'h0128_5020;  // rs=9, rt=8

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cur_pc;
  logic [W-1:0] if_instr;
  logic         pc_src;
  logic         ex_mem_read;
  logic [4:0]   ex_rt;
  logic [W-1:0] id_pc;
  logic [W-1:0] id_instr;
  logic         id_valid;
  logic         pc_delay;
  logic [W-1:0] pre_pc;
  logic         bubble;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]  stall_count;
  logic [31:0]  flush_count;
`endif

  if_id_stage #(.WIDTH(W), .NOP_INSTR(NOP)) dut (
    .CLK        (clk),
    .Reset      (rst),
    .curPC      (cur_pc),
    .IF_Instr   (if_instr),
    .PCSrc      (pc_src),
    .EX_MemRead (ex_mem_read),
    .EX_Rt      (ex_rt),
    .ID_PC      (id_pc),
    .ID_Instr   (id_instr),
    .ID_Valid   (id_valid),
    .PCdelay    (pc_delay),
    .prePC      (pre_pc),
`ifdef IF_ID_PERF_CNT_EN
    .StallCount (stall_count),
    .FlushCount (flush_count),
`endif
    .Bubble     (bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] pc;
    logic [W-1:0] instr;
    logic         src;
    logic         mr;
    logic [4:0]   rt;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_instr;
    logic         e_valid;
    logic         e_stall;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] pre_pc;
    logic [W-1:0] id_pc;
    logic [W-1:0] id_instr;
    logic         id_valid;
    logic         stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  // Each row: inputs for this cycle, and the outputs expected during this cycle.
  vec_t vecs[29] = '{
    '{1'b1, 32'h00, IA, 1'b0, 1'b0, 5'd0, 32'h00, NOP, 1'b0, 1'b0},
    '{1'b0, 32'h00, IA, 1'b0, 1'b0, 5'd0, 32'h00, NOP, 1'b0, 1'b0},
    '{1'b0, 32'h04, IB, 1'b0, 1'b0, 5'd0, 32'h00, IA,  1'b1, 1'b0},
    '{1'b0, 32'h08, IC, 1'b0, 1'b0, 5'd0, 32'h04, IB,  1'b1, 1'b0},
    '{1'b0, 32'h0C, IH, 1'b0, 1'b0, 5'd0, 32'h08, IC,  1'b1, 1'b0},
    '{1'b0, 32'h10, ID, 1'b0, 1'b1, 5'd8, 32'h0C, IH,  1'b1, 1'b1},
    '{1'b0, 32'h10, ID, 1'b0, 1'b1, 5'd8, 32'h0C, IH,  1'b1, 1'b0},
    '{1'b0, 32'h14, IE, 1'b0, 1'b0, 5'd0, 32'h10, ID,  1'b1, 1'b0},
    '{1'b0, 32'h18, IH, 1'b0, 1'b0, 5'd0, 32'h14, IE,  1'b1, 1'b0},
    '{1'b0, 32'h1C, IH, 1'b0, 1'b1, 5'd0, 32'h18, IH,  1'b1, 1'b0},
    '{1'b0, 32'h20, IF, 1'b0, 1'b0, 5'd8, 32'h1C, IH,  1'b1, 1'b0},
    '{1'b0, 32'h24, IA, 1'b1, 1'b0, 5'd0, 32'h20, IF,  1'b1, 1'b0},
    '{1'b0, 32'h40, IB, 1'b0, 1'b0, 5'd0, 32'h24, NOP, 1'b0, 1'b0},
    '{1'b0, 32'h44, IH, 1'b0, 1'b0, 5'd0, 32'h40, IB,  1'b1, 1'b0},
    '{1'b0, 32'h48, IC, 1'b1, 1'b1, 5'd9, 32'h44, IH,  1'b1, 1'b0},
    '{1'b0, 32'h60, ID, 1'b0, 1'b0, 5'd0, 32'h48, NOP, 1'b0, 1'b0},
    '{1'b0, 32'h64, IH, 1'b0, 1'b0, 5'd0, 32'h60, ID,  1'b1, 1'b0},
    '{1'b0, 32'h68, IE, 1'b0, 1'b1, 5'd9, 32'h64, IH,  1'b1, 1'b1},
    '{1'b1, 32'h68, IE, 1'b0, 1'b0, 5'd0, 32'h64, IH,  1'b1, 1'b0},
    '{1'b0, 32'h6C, IE, 1'b0, 1'b1, 5'd9, 32'h00, NOP, 1'b0, 1'b0},
    '{1'b0, 32'h70, IH, 1'b0, 1'b0, 5'd0, 32'h6C, IE,  1'b1, 1'b0},
    '{1'b0, 32'h74, IA, 1'b0, 1'b1, 5'd8, 32'h70, IH,  1'b1, 1'b1},
    '{1'b0, 32'h74, IA, 1'b1, 1'b0, 5'd0, 32'h70, IH,  1'b1, 1'b0},
    '{1'b0, 32'h80, IH, 1'b0, 1'b0, 5'd0, 32'h74, NOP, 1'b0, 1'b0},
    '{1'b0, 32'h84, IH, 1'b0, 1'b1, 5'd8, 32'h80, IH,  1'b1, 1'b1},
    '{1'b0, 32'h84, IH, 1'b0, 1'b0, 5'd0, 32'h80, IH,  1'b1, 1'b0},
    '{1'b0, 32'h88, IC, 1'b0, 1'b1, 5'd9, 32'h84, IH,  1'b1, 1'b1},
    '{1'b0, 32'h88, IC, 1'b0, 1'b0, 5'd0, 32'h84, IH,  1'b1, 1'b0},
    '{1'b0, 32'h8C, ID, 1'b0, 1'b0, 5'd0, 32'h88, IC,  1'b1, 1'b0}
  };

  // Monitor: samples just before the active edge, after inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("id_pc",    e.idx, id_pc,    e.id_pc);
        check("id_instr", e.idx, id_instr, e.id_instr);
        check("id_valid", e.idx, {31'd0, id_valid}, {31'd0, e.id_valid});
        check("pc_delay", e.idx, {31'd0, pc_delay}, {31'd0, e.stall});
        check("bubble",   e.idx, {31'd0, bubble},   {31'd0, e.stall});
        check("pre_pc",   e.idx, pre_pc,   e.pre_pc);
      end
    end
  end

  initial begin
    exp_t e;
    rst         = 1'b1;
    cur_pc      = '0;
    if_instr    = NOP;
    pc_src      = 1'b0;
    ex_mem_read = 1'b0;
    ex_rt       = 5'd0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      cur_pc      = vecs[i].pc;
      if_instr    = vecs[i].instr;
      pc_src      = vecs[i].src;
      ex_mem_read = vecs[i].mr;
      ex_rt       = vecs[i].rt;
      e.idx       = i;
      e.pre_pc    = vecs[i].pc;
      e.id_pc     = vecs[i].e_pc;
      e.id_instr  = vecs[i].e_instr;
      e.id_valid  = vecs[i].e_valid;
      e.stall     = vecs[i].e_stall;
      exp_q.push_back(e);
    end
    // Let the monitor drain, bounded to a few cycles.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    check("queue_drained", 0, exp_q.size(), 0);
`ifdef IF_ID_PERF_CNT_EN
    check("stall_count", 0, stall_count, 32'd5);
    check("flush_count", 0, flush_count, 32'd3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
